// File: rtl/aes_inv_cipher_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_cipher_core_pkg
// Description : Shared widths, round constants, FSM encoding and the
//               GF(2^8) helper functions of the AES-128 inverse cipher.
//               - xtime          : multiply one byte by x (0x02) mod 0x11b
//               - inv_shift_rows : rotate row r right by r byte positions
//               - inv_mix_column : multiply one column by {0e,0b,0d,09}
// Revision    : 1.0 - initial release
// ============================================================================
package aes_inv_cipher_core_pkg;

  localparam int KEY_WIDTH       = 128;
  localparam int TEXT_WIDTH      = 128;
  localparam int BYTE_WIDTH      = 8;
  localparam int FOUR_BYTE_WIDTH = 32;

  // AES-128 only; the round counter and number_o share this width.
  localparam int NR    = 10;
  localparam int RND_W = 4;

  localparam logic [RND_W-1:0] NR_RND   = RND_W'(NR);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [BYTE_WIDTH-1:0] xtime(input logic [BYTE_WIDTH-1:0] b);
    return {b[BYTE_WIDTH-2:0], 1'b0} ^ (b[BYTE_WIDTH-1] ? 8'h1b : 8'h00);
  endfunction

  // Bit 127 is s[0][0]; byte (r,c) sits at offset 8*(4*c + r) from the MSB.
  function automatic logic [TEXT_WIDTH-1:0] inv_shift_rows(input logic [TEXT_WIDTH-1:0] s);
    logic [TEXT_WIDTH-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[TEXT_WIDTH-1-BYTE_WIDTH*(4*c+r) -: BYTE_WIDTH] =
          s[TEXT_WIDTH-1-BYTE_WIDTH*(4*((c-r+4)%4)+r) -: BYTE_WIDTH];
      end
    end
    return o;
  endfunction

  // Coefficients built from shared xtime chains:
  // 9 = 8^1, b = 8^2^1, d = 8^4^1, e = 8^4^2.
  function automatic logic [FOUR_BYTE_WIDTH-1:0] inv_mix_column(
    input logic [FOUR_BYTE_WIDTH-1:0] col
  );
    logic [BYTE_WIDTH-1:0] a  [4];
    logic [BYTE_WIDTH-1:0] x2 [4];
    logic [BYTE_WIDTH-1:0] x4 [4];
    logic [BYTE_WIDTH-1:0] x8 [4];
    logic [BYTE_WIDTH-1:0] m9 [4];
    logic [BYTE_WIDTH-1:0] mb [4];
    logic [BYTE_WIDTH-1:0] md [4];
    logic [BYTE_WIDTH-1:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[FOUR_BYTE_WIDTH-1-BYTE_WIDTH*i -: BYTE_WIDTH];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_core_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_cipher_core_if
// Description : Key-expander and text handshake bundle of the inverse cipher.
//               master : drives keys, start/text (expander + text register)
//               slave  : the cipher core; returns number/ready/busy/done/plain
//   key_ready_i  1    all round keys built
//   key_first_i  128  round-10 key for the initial AddRoundKey
//   key_i        128  round key (10 - number_o)
//   number_o     4    round-key select, 0 when idle
//   start_i      1    one-cycle start request
//   text_i       128  ciphertext block
//   ready_o      1    start accepted this cycle
//   busy_o       1    rounds in progress
//   done_o       1    one-cycle pulse, plain_o valid
//   plain_o      128  plaintext block
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_core_if;
  import aes_inv_cipher_core_pkg::*;

  logic                  key_ready_i;
  logic [KEY_WIDTH-1:0]  key_first_i;
  logic [KEY_WIDTH-1:0]  key_i;
  logic [RND_W-1:0]      number_o;
  logic                  start_i;
  logic [TEXT_WIDTH-1:0] text_i;
  logic                  ready_o;
  logic                  busy_o;
  logic                  done_o;
  logic [TEXT_WIDTH-1:0] plain_o;

  modport master (
    output key_ready_i, key_first_i, key_i, start_i, text_i,
    input  number_o, ready_o, busy_o, done_o, plain_o
  );

  modport slave (
    input  key_ready_i, key_first_i, key_i, start_i, text_i,
    output number_o, ready_o, busy_o, done_o, plain_o
  );

endinterface
`default_nettype wire

// File: rtl/aes_inv_cipher_core_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_sbox
// Description : Combinational AES inverse S-box, 8-bit in -> 8-bit out.
//   in_i   8  byte to substitute
//   out_o  8  InvSubBytes(in_i)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox (
  input  wire logic [7:0] in_i,
  output      logic [7:0] out_o
);

  // Entry 0x00 occupies the top byte of the table.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_o = INV_SBOX[2047 - 8*in_i -: 8];

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_cipher_core
// Description : Iterative AES-128 inverse cipher, one round per clock.
//               Accepts a ciphertext on start, walks number_o 1..10 to fetch
//               round keys 9..0 from the expander, and pulses done_o with the
//               plaintext 10 cycles after acceptance.
//   clk_i   1  clock
//   rst_ni  1  synchronous active-low reset
//   bus        aes_inv_cipher_core_if.slave (keys, start/text, status, plain)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_core
  import aes_inv_cipher_core_pkg::*;
(
  input wire logic             clk_i,
  input wire logic             rst_ni,
  aes_inv_cipher_core_if.slave bus
);

  state_e                state_q, state_d;
  logic [RND_W-1:0]      rnd_q, rnd_d;
  logic [TEXT_WIDTH-1:0] st_q, st_d;
  logic [TEXT_WIDTH-1:0] plain_q, plain_d;
  logic                  done_q, done_d;

  logic                  w_accept;
  logic [TEXT_WIDTH-1:0] w_isr;
  logic [TEXT_WIDTH-1:0] w_isb;
  logic [TEXT_WIDTH-1:0] w_ark;
  logic [TEXT_WIDTH-1:0] w_imc;

  // ---------------------------------------------------------------------
  // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
  // ---------------------------------------------------------------------
  assign w_isr = inv_shift_rows(st_q);

  for (genvar i = 0; i < TEXT_WIDTH / BYTE_WIDTH; i++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .in_i  (w_isr[BYTE_WIDTH*i +: BYTE_WIDTH]),
      .out_o (w_isb[BYTE_WIDTH*i +: BYTE_WIDTH])
    );
  end

  assign w_ark = w_isb ^ bus.key_i;

  for (genvar c = 0; c < TEXT_WIDTH / FOUR_BYTE_WIDTH; c++) begin : g_mix
    assign w_imc[FOUR_BYTE_WIDTH*c +: FOUR_BYTE_WIDTH] =
      inv_mix_column(w_ark[FOUR_BYTE_WIDTH*c +: FOUR_BYTE_WIDTH]);
  end

  // ---------------------------------------------------------------------
  // Handshake and key select
  // ---------------------------------------------------------------------
  assign bus.ready_o  = (state_q == ST_IDLE) && bus.key_ready_i;
  assign w_accept     = bus.ready_o && bus.start_i;
  assign bus.busy_o   = (state_q == ST_RUN);
  // rnd counts 9..0, so the select walks 1..10 and the expander returns
  // round key (10 - number_o) == rnd in the same cycle.
  assign bus.number_o = (state_q == ST_RUN) ? (NR_RND - rnd_q) : '0;
  assign bus.done_o   = done_q;
  assign bus.plain_o  = plain_q;

  // ---------------------------------------------------------------------
  // FSM next state / datapath control
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    plain_d = plain_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          st_d    = bus.text_i ^ bus.key_first_i;
          rnd_d   = LAST_RND;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rnd_q != '0) begin
          st_d  = w_imc;
          rnd_d = rnd_q - RND_W'(1);
        end else begin
          // Final round skips InvMixColumns and lands in the output register.
          plain_d = w_ark;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      plain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      plain_q <= plain_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_cipher_core
// Description : Self-checking bench for aes_inv_cipher_core. Emulates the key
//               expander and compares every block against a reference
//               decryptor built from GF(2^8) arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_core;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0]   sbox   [256];
  logic [7:0]   isbox  [256];
  logic [127:0] rk_cur [11];

  aes_inv_cipher_core_if bus ();

  aes_inv_cipher_core dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Expander emulation: round key (10 - number_o), round-10 key for the load.
  assign bus.key_first_i = rk_cur[10];
  always_comb begin
    if (bus.number_o <= 4'd10) bus.key_i = rk_cur[10 - int'(bus.number_o)];
    else                       bus.key_i = 'x;
  end

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine(multiplicative inverse); inverse table by reverse lookup.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_cur[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] rk, o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    rk = rk_cur[10];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = ct[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      rk = rk_cur[rnd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = isbox[s[r][(c-r+4)%4]] ^ rk[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++) begin
          if (rnd > 0) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(t[j][c], coef[(j-i+4)%4]);
            s[i][c] = acc;
          end else begin
            s[i][c] = t[i][c];
          end
        end
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ------------------------------------------------------------------
  // Checking and sequencing helpers
  // ------------------------------------------------------------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a block and returns in its done_o cycle without advancing past it.
  // disturb=1 adds a start request mid-run and drops key_ready_i mid-run.
  task automatic do_block(input logic [127:0] ct, input logic [127:0] exp, input bit disturb);
    bus.text_i  = ct;
    bus.start_i = 1'b1;
    #1;
    chk("ready_at_start", 128'(bus.ready_o), 128'(1));
    tick();
    bus.start_i = 1'b0;
    bus.text_i  = ~ct;
    for (int k = 1; k <= 10; k++) begin
      if (disturb && k == 3) bus.start_i = 1'b1;
      if (disturb && k == 4) bus.start_i = 1'b0;
      if (disturb && k == 5) bus.key_ready_i = 1'b0;
      #1;
      chk("number_trace", 128'(bus.number_o), 128'(k));
      chk("busy_run", 128'(bus.busy_o), 128'(1));
      chk("done_low_run", 128'(bus.done_o), 128'(0));
      if (disturb && k == 3) chk("ready_mid_run", 128'(bus.ready_o), 128'(0));
      tick();
    end
    chk("done_pulse", 128'(bus.done_o), 128'(1));
    chk("plain", bus.plain_o, exp);
    chk("number_idle", 128'(bus.number_o), 128'(0));
    chk("busy_idle", 128'(bus.busy_o), 128'(0));
    bus.key_ready_i = 1'b1;
  endtask

  task automatic after_done(input logic [127:0] exp);
    tick();
    chk("done_single", 128'(bus.done_o), 128'(0));
    chk("plain_held", bus.plain_o, exp);
  endtask

  // ------------------------------------------------------------------
  // Directed sequence
  // ------------------------------------------------------------------
  initial begin
    logic [127:0] ct, ct2, pt, pt2, last_pt;

    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.text_i      = '0;
    bus.key_ready_i = 1'b0;
    for (int r = 0; r < 11; r++) rk_cur[r] = '0;
    build_tables();

    tick();
    tick();
    chk("rst_busy", 128'(bus.busy_o), 128'(0));
    chk("rst_done", 128'(bus.done_o), 128'(0));
    chk("rst_plain", bus.plain_o, 128'(0));
    chk("rst_number", 128'(bus.number_o), 128'(0));
    chk("rst_ready", 128'(bus.ready_o), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("ready_no_keys", 128'(bus.ready_o), 128'(0));

    // FIPS-197 C.1
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    bus.key_ready_i = 1'b1;
    do_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a,
             128'h00112233445566778899aabbccddeeff, 1'b0);
    after_done(128'h00112233445566778899aabbccddeeff);

    // FIPS-197 Appendix B
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_block(128'h3925841d02dc09fbdc118597196a0b32,
             128'h3243f6a8885a308d313198a2e0370734, 1'b0);
    after_done(128'h3243f6a8885a308d313198a2e0370734);

    // Start while keys are not ready: ignored, nothing queued.
    bus.key_ready_i = 1'b0;
    bus.text_i      = rand128();
    bus.start_i     = 1'b1;
    #1;
    chk("ready_keys_low", 128'(bus.ready_o), 128'(0));
    tick();
    bus.start_i     = 1'b0;
    bus.key_ready_i = 1'b1;
    chk("busy_keys_low", 128'(bus.busy_o), 128'(0));
    chk("number_keys_low", 128'(bus.number_o), 128'(0));
    tick();
    chk("done_keys_low", 128'(bus.done_o), 128'(0));
    chk("plain_keys_low", bus.plain_o, 128'h3243f6a8885a308d313198a2e0370734);

    // Random key: mid-run start and key_ready drop must not disturb the block.
    expand_key(rand128());
    ct = rand128();
    pt = ref_decrypt(ct);
    do_block(ct, pt, 1'b1);
    after_done(pt);

    // Back-to-back: second start in the first done cycle.
    ct  = rand128();
    ct2 = rand128();
    pt  = ref_decrypt(ct);
    pt2 = ref_decrypt(ct2);
    do_block(ct, pt, 1'b0);
    do_block(ct2, pt2, 1'b0);
    after_done(pt2);

    // Reset at round 5 aborts the block.
    ct          = rand128();
    bus.text_i  = ct;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    chk("number_round5", 128'(bus.number_o), 128'(5));
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 128'(bus.busy_o), 128'(0));
    chk("abort_done", 128'(bus.done_o), 128'(0));
    chk("abort_plain", bus.plain_o, 128'(0));
    chk("abort_number", 128'(bus.number_o), 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_done", 128'(bus.done_o), 128'(0));
    end
    pt = ref_decrypt(ct);
    do_block(ct, pt, 1'b0);
    after_done(pt);

    // Randomized keys and texts, back-to-back pairs.
    for (int n = 0; n < 5; n++) begin
      expand_key(rand128());
      ct  = rand128();
      ct2 = rand128();
      pt  = ref_decrypt(ct);
      pt2 = ref_decrypt(ct2);
      do_block(ct, pt, 1'b0);
      do_block(ct2, pt2, n[0]);
      last_pt = pt2;
      after_done(last_pt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
